game_sequencer: RTL and testbench
=================================

GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter MAX_LEVEL, default 9, meaning highest level reached (saturating).
REQ-002 SHALL have parameter HIT_TICKS, default 2, meaning tick_in pulses spent frozen after a hit.
REQ-003 SHALL have parameter LEVELUP_TICKS, default 3, meaning tick_in pulses spent frozen after reaching the top row.
REQ-004 SHALL have parameter OVER_TICKS, default 4, meaning tick_in pulses in GAME_OVER before returning to IDLE.
REQ-005 SHALL have port clk  input  1  system clock; all logic on posedge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port tick_in  input  1  one-clk pulse from frame/second divider.
REQ-008 SHALL have port start  input  1  debounced start button, level.
REQ-009 SHALL have port frog_at_top  input  1  frog occupies row 0.
REQ-010 SHALL have port collision_detected  input  1  frog controller hit flag.
REQ-011 SHALL have port lives  input  2  remaining lives from frog controller.
REQ-012 SHALL have port reset_frog  output  1  one-clk pulse returning frog to start cell.
REQ-013 SHALL have port reset_lives  output  1  one-clk pulse restoring 3 lives.
REQ-014 SHALL have port freeze  output  1  holds cars and frog input when high.
REQ-015 SHALL have port level  output  4  current level, 1..MAX_LEVEL.
REQ-016 SHALL have port speed_div  output  4  car step divisor, MAX_LEVEL+1-level.
REQ-017 SHALL have port game_state  output  3  encoded FSM state.
REQ-018 SHALL have port score  output  8  two BCD digits.

Function
REQ-019 SHALL implement FSM IDLE=0, PLAY=1, LEVEL_UP=2, HIT=3, GAME_OVER=4; all outputs registered.
REQ-020 SHALL detect start rising edge via registered start_q; start held high causes no repeat.
REQ-021 IDLE: freeze=1; start edge -> PLAY, level=1, reset_frog and reset_lives pulse in the transition cycle.
REQ-022 PLAY: freeze=0; priority lives==0 -> GAME_OVER, then collision_detected -> HIT, then frog_at_top -> LEVEL_UP.
REQ-023 Entry to LEVEL_UP SHALL pulse reset_frog once and increment level, saturating at MAX_LEVEL.
REQ-024 HIT, LEVEL_UP, GAME_OVER: freeze=1; pause counter cleared on entry, counts tick_in pulses; tick_in in the entry cycle not counted.
REQ-025 HIT exits to PLAY after HIT_TICKS counted ticks; LEVEL_UP after LEVELUP_TICKS; GAME_OVER to IDLE after OVER_TICKS.
REQ-026 start edges outside IDLE SHALL be ignored.
REQ-027 speed_div SHALL update in the same cycle as level; never 0.
REQ-028 reset_frog and reset_lives SHALL never exceed one clk high per event.

Reset
REQ-029 reset SHALL dominate all inputs in the same cycle.
REQ-030 Reset values: state IDLE, level 1, speed_div MAX_LEVEL, freeze 1, reset_frog 0, reset_lives 0, score 0, pause counter 0, start_q 1 (button held through reset does not start).
REQ-031 Reset mid-pause SHALL abandon the pause with no pulses emitted.

Configuration
REQ-032 Macro GAME_SEQUENCER_SCORE_EN defined: score +1 BCD on each LEVEL_UP entry, 99 wraps to 00, cleared on IDLE->PLAY.
REQ-033 Macro undefined: score port present, tied to 8'h00, no score registers.

Structure
REQ-034 Package game_pkg SHALL hold state encodings, GRID_COLS=20, GRID_ROWS=15, MAX_LIVES=3.
REQ-035 Sub-module pause_timer SHALL hold the tick counter (load, tick, done).

Verification
REQ-036 Reset with start=1, then hold start 10 clks -> stays IDLE; release and press -> PLAY, reset_frog=reset_lives=1 for one clk, level=1, speed_div=9.
REQ-037 PLAY, frog_at_top=1 -> LEVEL_UP, level=2, speed_div=8, reset_frog one pulse; 3 tick_in pulses -> PLAY, freeze=0.
REQ-038 PLAY, collision_detected=1, lives=2 -> HIT, freeze=1; tick_in on entry cycle then 2 more ticks -> PLAY on the second counted tick.
REQ-039 PLAY, lives=0 with collision_detected=1 and frog_at_top=1 same cycle -> GAME_OVER; 4 ticks -> IDLE.
REQ-040 Nine consecutive level-ups -> level stays 9, speed_div 1; SCORE_EN build: score 8'h09, 100 level-ups wrap to 8'h00.
REQ-041 reset asserted during LEVEL_UP pause -> next cycle IDLE, level 1, no reset_frog pulse.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the game sequencer: FSM encodings, play-field geometry, pause counter type.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package game_pkg;

   // Encoded FSM state as driven on game_state
   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE      = 3'd0;
   localparam state_t ST_PLAY      = 3'd1;
   localparam state_t ST_LEVEL_UP  = 3'd2;
   localparam state_t ST_HIT       = 3'd3;
   localparam state_t ST_GAME_OVER = 3'd4;

   // Play-field geometry and life budget shared with the frog/car controllers
   localparam int GRID_COLS = 20;
   localparam int GRID_ROWS = 15;
   localparam int MAX_LIVES = 3;

   // Pause counter width; tick budgets above 255 are not meaningful for a frozen screen
   localparam int PAUSE_CNT_W = 8;
   typedef logic [PAUSE_CNT_W-1:0] pause_cnt_t;

   // States in which the game is frozen waiting on the pause timer
   function automatic logic is_pause_state(input state_t s);
      return (s == ST_HIT) || (s == ST_LEVEL_UP) || (s == ST_GAME_OVER);
   endfunction

   // Two-digit BCD increment, 99 wraps to 00
   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      logic [3:0] ones;
      logic [3:0] tens;
      ones = v[3:0];
      tens = v[7:4];
      if (ones >= 4'd9) begin
         ones = 4'd0;
         tens = (tens >= 4'd9) ? 4'd0 : tens + 4'd1;
      end else begin
         ones = ones + 4'd1;
      end
      return {tens, ones};
   endfunction

endpackage

// File: rtl/game_sequencer_pause_timer.sv
// Counts tick pulses while the game is frozen and flags the tick that completes the pause.
// Latency: done is combinational on the completing tick; count clears one clk after load.
// Backpressure: none; load has priority over tick so a tick in the load cycle is not counted.
module pause_timer
   import game_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic       tick,
   input  pause_cnt_t limit,
   output logic       done
);

   pause_cnt_t count_q;
   pause_cnt_t count_d;

   // Next count: cleared on load, advanced by one per tick otherwise
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = '0;
      end else if (tick) begin
         count_d = count_q + pause_cnt_t'(1);
      end
   end

   // Completing tick: this tick brings the count up to the limit
   assign done = tick && !load && (count_q == (limit - pause_cnt_t'(1)));

   // Counter register
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/game_sequencer.sv
// Game flow controller: idle/play/level-up/hit/game-over sequencing, level and car speed, optional BCD score.
// Latency: all outputs registered, one clk after the inputs that cause them; pauses last N tick_in pulses.
// Backpressure: none; start is edge-detected, tick_in ignored outside pauses. Score enabled by GAME_SEQUENCER_SCORE_EN.
module game_sequencer
   import game_pkg::*;
#(
   parameter int MAX_LEVEL     = 9,
   parameter int HIT_TICKS     = 2,
   parameter int LEVELUP_TICKS = 3,
   parameter int OVER_TICKS    = 4
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       tick_in,
   input  logic       start,
   input  logic       frog_at_top,
   input  logic       collision_detected,
   input  logic [1:0] lives,
   output logic       reset_frog,
   output logic       reset_lives,
   output logic       freeze,
   output logic [3:0] level,
   output logic [3:0] speed_div,
   output logic [2:0] game_state,
   output logic [7:0] score
);

   localparam logic [3:0] LEVEL_TOP = 4'(MAX_LEVEL);

   state_t     state_q,       state_d;
   logic [3:0] level_q,       level_d;
   logic [3:0] speed_div_q,   speed_div_d;
   logic       freeze_q,      freeze_d;
   logic       reset_frog_q,  reset_frog_d;
   logic       reset_lives_q, reset_lives_d;
   logic       entry_q,       entry_d;
   logic       start_q;

   logic       start_edge;
   logic       game_start;
   logic       levelup_go;
   logic       pause_done;
   pause_cnt_t pause_limit;

   // start_q resets high so a button held through reset is not seen as a press
   assign start_edge = start && !start_q;
   assign game_start = (state_q == ST_IDLE) && start_edge;

   // Reaching the top row only counts when no loss or hit takes priority in the same cycle
   assign levelup_go = (state_q == ST_PLAY) && (lives != 2'd0) &&
                       !collision_detected && frog_at_top;

   // Tick budget for whichever pause is active
   always_comb begin
      pause_limit = '1;
      case (state_q)
         ST_HIT:       pause_limit = pause_cnt_t'(HIT_TICKS);
         ST_LEVEL_UP:  pause_limit = pause_cnt_t'(LEVELUP_TICKS);
         ST_GAME_OVER: pause_limit = pause_cnt_t'(OVER_TICKS);
         default:      pause_limit = '1;
      endcase
   end

   // The timer is cleared during the first cycle of each pause, so a tick there is not counted
   pause_timer u_pause_timer (
      .clk   (clk),
      .reset (reset),
      .load  (entry_q),
      .tick  (tick_in && is_pause_state(state_q)),
      .limit (pause_limit),
      .done  (pause_done)
   );

   // Next-state, level and pulse decode
   always_comb begin
      state_d       = state_q;
      level_d       = level_q;
      reset_frog_d  = 1'b0;
      reset_lives_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (game_start) begin
               state_d       = ST_PLAY;
               level_d       = 4'd1;
               reset_frog_d  = 1'b1;
               reset_lives_d = 1'b1;
            end
         end
         ST_PLAY: begin
            if (lives == 2'd0) begin
               state_d = ST_GAME_OVER;
            end else if (collision_detected) begin
               state_d = ST_HIT;
            end else if (levelup_go) begin
               state_d      = ST_LEVEL_UP;
               reset_frog_d = 1'b1;
               level_d      = (level_q >= LEVEL_TOP) ? LEVEL_TOP : level_q + 4'd1;
            end
         end
         ST_HIT, ST_LEVEL_UP: begin
            if (pause_done) begin
               state_d = ST_PLAY;
            end
         end
         ST_GAME_OVER: begin
            if (pause_done) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs derived from the next state so they register alongside it
   always_comb begin
      speed_div_d = LEVEL_TOP + 4'd1 - level_d;
      freeze_d    = (state_d != ST_PLAY);
      entry_d     = is_pause_state(state_d) && (state_d != state_q);
   end

   // Control registers; reset abandons any pause and suppresses pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         level_q       <= 4'd1;
         speed_div_q   <= LEVEL_TOP;
         freeze_q      <= 1'b1;
         reset_frog_q  <= 1'b0;
         reset_lives_q <= 1'b0;
         entry_q       <= 1'b0;
         start_q       <= 1'b1;
      end else begin
         state_q       <= state_d;
         level_q       <= level_d;
         speed_div_q   <= speed_div_d;
         freeze_q      <= freeze_d;
         reset_frog_q  <= reset_frog_d;
         reset_lives_q <= reset_lives_d;
         entry_q       <= entry_d;
         start_q       <= start;
      end
   end

`ifdef GAME_SEQUENCER_SCORE_EN
   logic [7:0] score_q, score_d;

   // Score: cleared on a new game, one BCD count per level-up entry
   always_comb begin
      score_d = score_q;
      if (game_start) begin
         score_d = 8'h00;
      end else if (levelup_go) begin
         score_d = bcd_inc(score_q);
      end
   end

   // Score register
   always_ff @(posedge clk) begin
      if (reset) begin
         score_q <= 8'h00;
      end else begin
         score_q <= score_d;
      end
   end

   assign score = score_q;
`else
   assign score = 8'h00;
`endif

   assign reset_frog  = reset_frog_q;
   assign reset_lives = reset_lives_q;
   assign freeze      = freeze_q;
   assign level       = level_q;
   assign speed_div   = speed_div_q;
   assign game_state  = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with a per-cycle expectation queue.
// Latency: expectations are popped and compared 1 time unit after each rising edge.
// Backpressure: none; every step is a fixed number of clocks.
module tb_game_sequencer;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_PLAY = 3'd1;
   localparam logic [2:0] S_LVUP = 3'd2;
   localparam logic [2:0] S_HIT  = 3'd3;
   localparam logic [2:0] S_OVER = 3'd4;

   logic       clk = 1'b0;
   logic       reset, tick_in, start, frog_at_top, collision_detected;
   logic [1:0] lives;
   logic       reset_frog, reset_lives, freeze;
   logic [3:0] level, speed_div;
   logic [2:0] game_state;
   logic [7:0] score;

   typedef struct {
      string      tag;
      logic [2:0] st;
      logic [3:0] lvl;
      logic [3:0] spd;
      logic       frz;
      logic       rf;
      logic       rl;
      logic [7:0] sc;
   } exp_t;

   exp_t sb[$];
   int   checks    = 0;
   int   passed    = 0;
   int   score_dec = 0;

   always #5 clk = ~clk;

   game_sequencer dut (
      .clk                (clk),
      .reset              (reset),
      .tick_in            (tick_in),
      .start              (start),
      .frog_at_top        (frog_at_top),
      .collision_detected (collision_detected),
      .lives              (lives),
      .reset_frog         (reset_frog),
      .reset_lives        (reset_lives),
      .freeze             (freeze),
      .level              (level),
      .speed_div          (speed_div),
      .game_state         (game_state),
      .score              (score)
   );

   task automatic chk(input string tag, input string fld, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) passed++;
      else $error("FAIL %s.%s got=%0h expected=%0h", tag, fld, got, exp);
   endtask

   // Queue the expected post-edge outputs, clock once, then pop and compare
   task automatic cyc(input string tag, input logic [2:0] st, input int lvl,
                      input logic frz, input logic rf, input logic rl);
      exp_t e;
      e.tag = tag;
      e.st  = st;
      e.lvl = 4'(lvl);
      e.spd = 4'(10 - lvl);
      e.frz = frz;
      e.rf  = rf;
      e.rl  = rl;
      e.sc  = {4'(score_dec / 10), 4'(score_dec % 10)};
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk(e.tag, "state", {5'b0, game_state},  {5'b0, e.st});
      chk(e.tag, "level", {4'b0, level},       {4'b0, e.lvl});
      chk(e.tag, "speed", {4'b0, speed_div},   {4'b0, e.spd});
      chk(e.tag, "freeze", {7'b0, freeze},     {7'b0, e.frz});
      chk(e.tag, "rfrog", {7'b0, reset_frog},  {7'b0, e.rf});
      chk(e.tag, "rlives", {7'b0, reset_lives}, {7'b0, e.rl});
      chk(e.tag, "score", score,               e.sc);
   endtask

   task automatic bump_score();
`ifdef GAME_SEQUENCER_SCORE_EN
      score_dec = (score_dec + 1) % 100;
`endif
   endtask

   // Reach the top row, sit through the level-up pause, return to play
   task automatic level_up(input int new_lvl);
      frog_at_top = 1'b1;
      bump_score();
      cyc("lvup", S_LVUP, new_lvl, 1'b1, 1'b1, 1'b0);
      frog_at_top = 1'b0;
      tick_in     = 1'b1;
      cyc("lv_entry", S_LVUP, new_lvl, 1'b1, 1'b0, 1'b0);
      cyc("lv_t1", S_LVUP, new_lvl, 1'b1, 1'b0, 1'b0);
      cyc("lv_t2", S_LVUP, new_lvl, 1'b1, 1'b0, 1'b0);
      cyc("lv_t3", S_PLAY, new_lvl, 1'b0, 1'b0, 1'b0);
      tick_in = 1'b0;
   endtask

   initial begin
      int n_lvups;
      reset = 1'b1; start = 1'b1; tick_in = 1'b0;
      frog_at_top = 1'b0; collision_detected = 1'b0; lives = 2'd3;

      // Reset with start held, then keep start held: no game begins
      cyc("rst0", S_IDLE, 1, 1'b1, 1'b0, 1'b0);
      cyc("rst1", S_IDLE, 1, 1'b1, 1'b0, 1'b0);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) cyc("hold", S_IDLE, 1, 1'b1, 1'b0, 1'b0);

      // Release and press: single-clock frog/lives pulses
      start = 1'b0;
      cyc("release", S_IDLE, 1, 1'b1, 1'b0, 1'b0);
      start = 1'b1;
      score_dec = 0;
      cyc("start", S_PLAY, 1, 1'b0, 1'b1, 1'b1);
      cyc("play", S_PLAY, 1, 1'b0, 1'b0, 1'b0);

      // A fresh press during play is ignored
      start = 1'b0;
      cyc("play_rel", S_PLAY, 1, 1'b0, 1'b0, 1'b0);
      start = 1'b1;
      cyc("play_press", S_PLAY, 1, 1'b0, 1'b0, 1'b0);

      level_up(2);

      // Hit: tick on entry cycle not counted, second counted tick returns to play
      lives = 2'd2; collision_detected = 1'b1;
      cyc("hit", S_HIT, 2, 1'b1, 1'b0, 1'b0);
      collision_detected = 1'b0; tick_in = 1'b1;
      cyc("hit_entry", S_HIT, 2, 1'b1, 1'b0, 1'b0);
      cyc("hit_t1", S_HIT, 2, 1'b1, 1'b0, 1'b0);
      cyc("hit_t2", S_PLAY, 2, 1'b0, 1'b0, 1'b0);
      tick_in = 1'b0;

      // Out of lives wins over collision and top-row in the same cycle
      lives = 2'd0; collision_detected = 1'b1; frog_at_top = 1'b1;
      cyc("over", S_OVER, 2, 1'b1, 1'b0, 1'b0);
      lives = 2'd3; collision_detected = 1'b0; frog_at_top = 1'b0; tick_in = 1'b1;
      cyc("over_entry", S_OVER, 2, 1'b1, 1'b0, 1'b0);
      cyc("over_t1", S_OVER, 2, 1'b1, 1'b0, 1'b0);
      cyc("over_t2", S_OVER, 2, 1'b1, 1'b0, 1'b0);
      cyc("over_t3", S_OVER, 2, 1'b1, 1'b0, 1'b0);
      cyc("over_t4", S_IDLE, 2, 1'b1, 1'b0, 1'b0);
      tick_in = 1'b0;

      // New game: level back to 1, score cleared
      start = 1'b0;
      cyc("idle2", S_IDLE, 2, 1'b1, 1'b0, 1'b0);
      start = 1'b1;
      score_dec = 0;
      cyc("start2", S_PLAY, 1, 1'b0, 1'b1, 1'b1);

      // Level saturation at 9 (speed 1); score build runs long enough to wrap
`ifdef GAME_SEQUENCER_SCORE_EN
      n_lvups = 100;
`else
      n_lvups = 10;
`endif
      for (int i = 1; i <= n_lvups; i++) level_up((i + 1 > 9) ? 9 : i + 1);

      // Reset in the middle of a level-up pause
      frog_at_top = 1'b1;
      bump_score();
      cyc("lv_pre_rst", S_LVUP, 9, 1'b1, 1'b1, 1'b0);
      frog_at_top = 1'b0; tick_in = 1'b1;
      cyc("lv_entry_rst", S_LVUP, 9, 1'b1, 1'b0, 1'b0);
      cyc("lv_t1_rst", S_LVUP, 9, 1'b1, 1'b0, 1'b0);
      reset = 1'b1;
      score_dec = 0;
      cyc("mid_rst", S_IDLE, 1, 1'b1, 1'b0, 1'b0);
      reset = 1'b0;
      cyc("post_rst0", S_IDLE, 1, 1'b1, 1'b0, 1'b0);
      cyc("post_rst1", S_IDLE, 1, 1'b1, 1'b0, 1'b0);
      tick_in = 1'b0;

      // Reset dominates a start edge in the same cycle
      start = 1'b0;
      cyc("pre_dom", S_IDLE, 1, 1'b1, 1'b0, 1'b0);
      reset = 1'b1; start = 1'b1;
      cyc("rst_dom", S_IDLE, 1, 1'b1, 1'b0, 1'b0);
      reset = 1'b0;
      cyc("rst_dom_after", S_IDLE, 1, 1'b1, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
